mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory request port between NUM_REQ request queues (icache miss, dcache miss,
//   victim writeback, prefetch). Round-robin selects a non-empty queue, pops it, registers the entry
//   and holds it on the memory port until accepted. It tracks in-order outstanding requests in an
//   internal ID FIFO and steers each memory response back to the requester that issued it.
// PARAMETERS
//   NUM_REQ          4    number of requesters (>=2)
//   REQ_WIDTH        64   request entry width in bits
//   MAX_OUTSTANDING  8    max accepted-but-unanswered requests (ID FIFO depth, >=1)
// PORTS
//   clk             in   1                   clock
//   reset           in   1                   synchronous, active-high reset
//   req_valid       in   NUM_REQ             per-queue not_empty
//   req_data        in   NUM_REQ*REQ_WIDTH   per-queue head entry; requester i at [i*REQ_WIDTH +: REQ_WIDTH]
//   req_pop         out  NUM_REQ             one-hot pop to the winning queue; 0 when no capture
//   grant           out  NUM_REQ             one-hot select of winner; equals req_pop
//   mem_req_valid   out  1                   registered request valid
//   mem_req_data    out  REQ_WIDTH           registered request entry
//   mem_req_ready   in   1                   memory accepts request when valid && ready
//   mem_resp_valid  in   1                   in-order response strobe, 1 cycle per response
//   resp_sel        out  NUM_REQ             one-hot owner of current response; 0 when no response
//   outstanding     out  $clog2(MAX_OUTSTANDING+1)   accepted, unanswered count
//   resp_error      out  1                   sticky: response arrived with outstanding==0
// BEHAVIOUR
//   Reset: state IDLE, mem_req_valid=0, mem_req_data=0, outstanding=0, rr_ptr=0, ID FIFO empty,
//     resp_error=0; req_pop/grant/resp_sel=0. Reset mid-operation drops held request and all IDs.
//   States: IDLE (mem_req_valid=0), HOLD (mem_req_valid=1, data stable until accepted).
//   accept = HOLD && mem_req_ready.  resp = mem_resp_valid && outstanding!=0.
//   Capacity: capture allowed iff outstanding + accept - resp < MAX_OUTSTANDING (evaluated same cycle).
//   Capture: allowed && any req_valid && (IDLE || accept). Winner = first i with req_valid[i]
//     scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_pop/grant combinational one-hot of winner in
//     that cycle only; on the edge mem_req_data <= req_data[winner], rr_ptr <= (winner+1) mod NUM_REQ,
//     state <= HOLD. Capture latency: queue head to mem_req_valid = 1 cycle.
//   Transitions: IDLE->HOLD on capture; HOLD->HOLD on accept with capture (back-to-back, 1 req/cycle);
//     HOLD->IDLE on accept without capture; HOLD held while !mem_req_ready (no re-arbitration).
//   On accept: push held requester index into ID FIFO; outstanding++.
//   On resp: resp_sel = one-hot(ID FIFO head) combinational same cycle; pop FIFO; outstanding--.
//   Accept and resp same cycle: push+pop both happen, outstanding unchanged.
//   mem_resp_valid with outstanding==0: ignored (resp_sel=0, no count change), resp_error <= 1
//     until reset.
//   outstanding never exceeds MAX_OUTSTANDING; ID FIFO wraps modulo MAX_OUTSTANDING.
//   Requester dropping req_valid without pop is legal; only captured entries are popped.
// TESTING
//   Single req: reset, req_valid=0001, data0=0xA5 -> req_pop=0001 one cycle; next cycle
//     mem_req_valid=1, data=0xA5; ready=1 -> outstanding=1; resp -> resp_sel=0001, outstanding=0.
//   Fairness: req_valid=1111 held, ready=1 -> grant sequence 0001,0010,0100,1000,0001 back-to-back.
//   Backpressure: ready=0 for 5 cycles -> mem_req_data stable, req_pop=0, no rr_ptr change;
//     ready=1 -> accepted once, outstanding=1.
//   Credit limit: MAX_OUTSTANDING=8, no responses -> exactly 8 accepts, then req_pop stays 0;
//     one resp same cycle as 8th accept -> 9th capture allowed that cycle.
//   Ordering: issue from req 2,0,3 -> three responses give resp_sel 0100,0001,1000.
//   Error/reset: resp with outstanding=0 -> resp_error=1, outstanding stays 0; reset in HOLD with
//     outstanding=3 -> mem_req_valid=0, outstanding=0, resp_error=0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the request-queue side and memory-port side signals of mem_port_arbiter.
// Handshake: a memory request transfers on a cycle where mem_req_valid && mem_req_ready; valid and data hold until then.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int REQ_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*REQ_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_pop;
    logic [NUM_REQ-1:0]           grant;
    logic                         mem_req_valid;
    logic [REQ_WIDTH-1:0]         mem_req_data;
    logic                         mem_req_ready;
    logic                         mem_resp_valid;
    logic [NUM_REQ-1:0]           resp_sel;
    logic [OW-1:0]                outstanding;
    logic                         resp_error;

    // master: the arbiter itself; slave: the queues and memory around it
    modport master (
        input  req_valid, req_data, mem_req_ready, mem_resp_valid,
        output req_pop, grant, mem_req_valid, mem_req_data, resp_sel, outstanding, resp_error
    );
    modport slave (
        output req_valid, req_data, mem_req_ready, mem_resp_valid,
        input  req_pop, grant, mem_req_valid, mem_req_data, resp_sel, outstanding, resp_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request port among NUM_REQ queues, with an in-order
// ID FIFO that steers each memory response back to the requester that issued it.
module mem_port_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int REQ_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output logic                state_dbg_o
);
    localparam int PW  = $clog2(NUM_REQ);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OW:0] MAX_W    = (OW + 1)'(MAX_OUTSTANDING);
    localparam logic [PW:0] NR_W     = (PW + 1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST_R = PW'(NUM_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q;
    logic                   mem_valid_q;
    logic [REQ_WIDTH-1:0]   mem_data_q;
    logic [PW-1:0]          held_id_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic                   resp_error_q;
    logic [FW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]          id_mem_q [MAX_OUTSTANDING];

    logic                   accept, resp, capture, found;
    logic [OW:0]            occ_next;
    logic [PW:0]            scan;
    logic [PW-1:0]          win_idx, rr_next;
    logic [REQ_WIDTH-1:0]   cap_data;
    logic [NUM_REQ-1:0]     pop_vec, sel_vec;

    function automatic logic [FW-1:0] fifo_inc(input logic [FW-1:0] p);
        return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + FW'(1);
    endfunction

    always_comb begin
        accept   = (state_q == HOLD) && bus.mem_req_ready && !reset;
        resp     = bus.mem_resp_valid && (outstanding_q != '0) && !reset;
        // occupancy as it will stand after this edge; a same-cycle response frees a credit
        occ_next = {1'b0, outstanding_q} + (OW + 1)'(accept) - (OW + 1)'(resp);
        outstanding_d = occ_next[OW-1:0];

        found   = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (PW + 1)'(i);
            if (scan >= NR_W) scan = scan - NR_W;
            if (!found && bus.req_valid[scan[PW-1:0]]) begin
                found   = 1'b1;
                win_idx = scan[PW-1:0];
            end
        end

        cap_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) cap_data = bus.req_data[i*REQ_WIDTH +: REQ_WIDTH];
        end

        rr_next = (win_idx == LAST_R) ? '0 : win_idx + PW'(1);
        capture = !reset && (occ_next < MAX_W) && found && ((state_q == IDLE) || accept);
        pop_vec = capture ? (NUM_REQ'(1) << win_idx) : '0;
        sel_vec = resp ? (NUM_REQ'(1) << id_mem_q[rd_ptr_q]) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_valid_q   <= 1'b0;
            mem_data_q    <= '0;
            held_id_q     <= '0;
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            resp_error_q  <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (bus.mem_resp_valid && (outstanding_q == '0)) resp_error_q <= 1'b1;
            if (accept) begin
                id_mem_q[wr_ptr_q] <= held_id_q;
                wr_ptr_q           <= fifo_inc(wr_ptr_q);
            end
            if (resp) rd_ptr_q <= fifo_inc(rd_ptr_q);
            if (capture) begin
                state_q     <= HOLD;
                mem_valid_q <= 1'b1;
                mem_data_q  <= cap_data;
                held_id_q   <= win_idx;
                rr_ptr_q    <= rr_next;
            end else if (accept) begin
                state_q     <= IDLE;
                mem_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_pop       = pop_vec;
    assign bus.grant         = pop_vec;
    assign bus.resp_sel      = sel_vec;
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_data  = mem_data_q;
    assign bus.outstanding   = outstanding_q;
    assign bus.resp_error    = resp_error_q;
    assign state_dbg_o       = (state_q == HOLD);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a queue-based reference model predicts grants, response owners
// and counters each cycle; captured entries go into exp_q, checked by a monitor at acceptance.
module tb_mem_port_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int M = 8;

    logic clk;
    logic reset;
    logic state_dbg;

    mem_port_arbiter_if #(.NUM_REQ(N), .REQ_WIDTH(W), .MAX_OUTSTANDING(M)) bus ();

    mem_port_arbiter #(.NUM_REQ(N), .REQ_WIDTH(W), .MAX_OUTSTANDING(M)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .state_dbg_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q [$];

    // reference model state
    bit       chk_on = 0;
    bit       held   = 0;
    int       held_id = 0;
    int       rr     = 0;
    int       idq [$];
    bit       err    = 0;
    logic [N-1:0] m_pop, m_sel;
    bit       m_acc, m_cap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval(input logic rst);
        bit acc, rsp, ok;
        int win, occ;
        logic [N-1:0] ep, es;
        occ = idq.size();
        acc = held && bus.mem_req_ready && !rst;
        rsp = bus.mem_resp_valid && (occ != 0) && !rst;
        ok  = (occ + int'(acc) - int'(rsp)) < M;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (win < 0 && bus.req_valid[j]) win = j;
        end
        m_cap = !rst && ok && (win >= 0) && (!held || acc);
        m_acc = acc;
        ep = m_cap ? N'(1 << win) : '0;
        es = rsp ? N'(1 << idq[0]) : '0;
        m_pop = bus.req_pop;
        m_sel = bus.resp_sel;
        if (chk_on) begin
            chk("req_pop", bus.req_pop, ep);
            chk("grant", bus.grant, ep);
            chk("resp_sel", bus.resp_sel, es);
            chk("mem_req_valid", bus.mem_req_valid, held);
            chk("state_dbg", state_dbg, held);
            chk("outstanding", bus.outstanding, occ);
            chk("resp_error", bus.resp_error, err);
        end
        if (rst) begin
            held = 0; rr = 0; err = 0;
            idq.delete();
            exp_q.delete();
        end else begin
            if (bus.mem_resp_valid && occ == 0) err = 1;
            if (rsp) void'(idq.pop_front());
            if (acc) begin
                idq.push_back(held_id);
                held = 0;
            end
            if (m_cap) begin
                held    = 1;
                held_id = win;
                rr      = (win + 1) % N;
                exp_q.push_back(bus.req_data[win*W +: W]);
            end
        end
    endtask

    // driver: called at a falling edge, returns at the next falling edge
    task automatic cyc(input logic [N-1:0] v, input logic rdy, input logic rv, input logic rst);
        bus.req_valid      = v;
        bus.mem_req_ready  = rdy;
        bus.mem_resp_valid = rv;
        reset              = rst;
        #1;
        model_eval(rst);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        cyc('0, 1'b0, 1'b0, 1'b1);
    endtask

    // monitor: checks the held request against the scoreboard and retires it on acceptance
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && bus.mem_req_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL mem_req_unexpected: got %0h expected none", bus.mem_req_data);
                end else begin
                    chk("mem_req_data", bus.mem_req_data, exp_q[0]);
                    if (bus.mem_req_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [N-1:0] seq [5];
        logic [N-1:0] fair_exp [5];
        int n_acc;
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
        reset = 1'b1;
        bus.req_valid = '0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        rand_data();
        @(negedge clk);
        do_reset();
        chk_on = 1;
        do_reset();
        chk("reset_valid", bus.mem_req_valid, 0);
        chk("reset_data", bus.mem_req_data, 0);
        chk("reset_outstanding", bus.outstanding, 0);

        // single request round trip
        bus.req_data[0 +: W] = 64'hA5;
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        chk("single_pop", m_pop, 4'b0001);
        chk("single_valid", bus.mem_req_valid, 1);
        chk("single_data", bus.mem_req_data, 64'hA5);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("single_outstanding", bus.outstanding, 1);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("single_resp_sel", m_sel, 4'b0001);
        chk("single_out_zero", bus.outstanding, 0);

        // fairness, back-to-back
        do_reset();
        rand_data();
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b1, 1'b0, 1'b0);
            seq[i] = m_pop;
        end
        for (int i = 0; i < 5; i++) chk($sformatf("fair_grant_%0d", i), seq[i], fair_exp[i]);

        // backpressure
        do_reset();
        rand_data();
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b0, 1'b0, 1'b0);
            chk("bp_no_pop", m_pop, 0);
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("bp_rr_kept", m_pop, 4'b0010);
        chk("bp_outstanding", bus.outstanding, 1);

        // credit limit without responses
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            cyc(4'b1111, 1'b1, 1'b0, 1'b0);
            if (m_acc) n_acc++;
        end
        chk("credit_accepts", n_acc, 8);
        chk("credit_no_pop", m_pop, 0);
        chk("credit_outstanding", bus.outstanding, 8);

        // response on the 8th accept frees a credit that same cycle
        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'b1111, 1'b1, 1'b0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("credit_reuse_pop", m_pop, 4'b0001);
        chk("credit_reuse_sel", m_sel, 4'b0001);

        // response ordering
        do_reset();
        rand_data();
        cyc(4'b0100, 1'b0, 1'b0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("order_0", m_sel, 4'b0100);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("order_1", m_sel, 4'b0001);
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("order_2", m_sel, 4'b1000);

        // stray response, then reset while holding with 3 outstanding
        cyc(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("err_sel_zero", m_sel, 0);
        chk("err_flag", bus.resp_error, 1);
        chk("err_out_zero", bus.outstanding, 0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_out", bus.outstanding, 3);
        do_reset();
        chk("post_reset_valid", bus.mem_req_valid, 0);
        chk("post_reset_out", bus.outstanding, 0);
        chk("post_reset_err", bus.resp_error, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rand_data();
            cyc(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end

        // drain
        for (int i = 0; i < 40; i++) begin
            if (!held && idq.size() == 0) break;
            cyc('0, 1'b1, 1'b1, 1'b0);
        end
        chk("drain_valid", bus.mem_req_valid, 0);
        chk("drain_outstanding", bus.outstanding, 0);
        chk("drain_scoreboard", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
